// File: rtl/reversi_flip_engine.sv
// Reversi move resolver for an N x N board: scans eight directions from the target cell,
// flips bracketed opponent pieces one per draw handshake, then places the mover's piece.
module reversi_flip_engine #(
    parameter int N = 8,
    localparam int CW = $clog2(N),
    localparam int FW = $clog2(8 * N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CW-1:0]     px,
    input  logic [CW-1:0]     py,
    input  logic [1:0]        colour,
    input  logic              check_only,
    input  logic [2*N*N-1:0]  board_in,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic [FW-1:0]     flip_count,
    output logic [2*N*N-1:0]  board_out,
    output logic              draw_req,
    input  logic              draw_ready,
    output logic [CW-1:0]     draw_x,
    output logic [CW-1:0]     draw_y,
    output logic [1:0]        draw_colour
);
    localparam int PW = CW + 2;
    localparam int BW = 2 * N * N;
    localparam logic signed [PW-1:0] ZERO = '0;
    localparam logic signed [PW-1:0] NP = PW'(N);

    typedef enum logic [2:0] {
        S_IDLE, S_ORIGIN, S_SCAN, S_FLIP, S_NEXT, S_PLACE, S_PLACE_DRAW, S_DONE
    } state_t;
    state_t state, state_n;

    logic [CW-1:0]        tx, ty;
    logic [1:0]           col;
    logic                 chk;
    logic [2:0]           dir;
    logic [CW:0]          k, rem;
    logic signed [PW-1:0] sx, sy;

    // Direction order E, NE, N, NW, W, SW, S, SE with y growing downward.
    function automatic logic signed [PW-1:0] step_dx(input logic [2:0] d);
        logic signed [1:0] v;
        case (d)
            3'd0, 3'd1, 3'd7: v = 2'sb01;
            3'd3, 3'd4, 3'd5: v = 2'sb11;
            default:          v = 2'sb00;
        endcase
        return PW'(v);
    endfunction

    function automatic logic signed [PW-1:0] step_dy(input logic [2:0] d);
        logic signed [1:0] v;
        case (d)
            3'd1, 3'd2, 3'd3: v = 2'sb11;
            3'd5, 3'd6, 3'd7: v = 2'sb01;
            default:          v = 2'sb00;
        endcase
        return PW'(v);
    endfunction

    function automatic logic [1:0] cell_at(input logic [BW-1:0] b, input int idx);
        return b[2*idx +: 2];
    endfunction

    logic signed [PW-1:0] ox, oy, stx, sty, fx1, fy1;
    logic [CW-1:0]        nx, ny;
    logic [1:0]           scell, opp;
    logic                 in_b, ok_xy, origin_ok, scan_opp, scan_hit, xfer;
    int                   sidx, oidx, fidx1, nidx;

    always_comb begin
        ox    = $signed({2'b00, tx});
        oy    = $signed({2'b00, ty});
        stx   = step_dx(dir);
        sty   = step_dy(dir);
        fx1   = ox + stx;
        fy1   = oy + sty;
        nx    = draw_x + stx[CW-1:0];
        ny    = draw_y + sty[CW-1:0];
        // Bounds are checked on signed coordinates so a step past either edge never wraps.
        in_b  = (sx >= ZERO) && (sx < NP) && (sy >= ZERO) && (sy < NP);
        sidx  = in_b ? int'(sy) * N + int'(sx) : 0;
        ok_xy = ({1'b0, tx} < (CW+1)'(N)) && ({1'b0, ty} < (CW+1)'(N));
        oidx  = ok_xy ? int'(ty) * N + int'(tx) : 0;
        fidx1 = int'(fy1) * N + int'(fx1);
        nidx  = int'(ny) * N + int'(nx);
        opp   = (col == 2'b01) ? 2'b10 : 2'b01;
        scell = cell_at(board_out, sidx);
        origin_ok = ok_xy && (col == 2'b01 || col == 2'b10) && (cell_at(board_out, oidx) == 2'b00);
        scan_opp  = in_b && (scell == opp);
        scan_hit  = in_b && (scell == col) && (k != '0);
        xfer      = draw_req && draw_ready;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:       if (start) state_n = S_ORIGIN;
            S_ORIGIN:     state_n = origin_ok ? S_SCAN : S_DONE;
            S_SCAN: begin
                if (scan_opp)                state_n = S_SCAN;
                else if (scan_hit && !chk)   state_n = S_FLIP;
                else                         state_n = S_NEXT;
            end
            S_FLIP:       if (xfer && rem == (CW+1)'(1)) state_n = S_NEXT;
            S_NEXT:       state_n = (dir == 3'd7) ? S_PLACE : S_SCAN;
            S_PLACE:      state_n = (flip_count == '0 || chk) ? S_DONE : S_PLACE_DRAW;
            S_PLACE_DRAW: if (xfer) state_n = S_DONE;
            S_DONE:       state_n = S_IDLE;
            default:      state_n = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

    // Request latches and scan walker; only meaningful while busy.
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: begin
                if (start) begin
                    tx  <= px;
                    ty  <= py;
                    col <= colour;
                    chk <= check_only;
                end
            end
            S_ORIGIN: begin
                dir <= '0;
                k   <= '0;
                sx  <= ox + step_dx(3'd0);
                sy  <= oy + step_dy(3'd0);
            end
            S_SCAN: begin
                if (scan_opp) begin
                    k  <= k + 1'b1;
                    sx <= sx + stx;
                    sy <= sy + sty;
                end else if (scan_hit) begin
                    rem <= k;
                end
            end
            S_FLIP: if (xfer) rem <= rem - 1'b1;
            S_NEXT: begin
                if (dir != 3'd7) begin
                    dir <= dir + 3'd1;
                    k   <= '0;
                    sx  <= ox + step_dx(dir + 3'd1);
                    sy  <= oy + step_dy(dir + 3'd1);
                end
            end
            default: ;
        endcase
    end

    // Control state, results, working board and the registered draw port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            valid       <= 1'b0;
            flip_count  <= '0;
            board_out   <= '0;
            draw_req    <= 1'b0;
            draw_x      <= '0;
            draw_y      <= '0;
            draw_colour <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        board_out  <= board_in;
                        flip_count <= '0;
                        valid      <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (!scan_opp && scan_hit) begin
                        flip_count <= flip_count + FW'(k);
                        if (!chk) begin
                            board_out[2*fidx1 +: 2] <= col;
                            draw_req    <= 1'b1;
                            draw_x      <= fx1[CW-1:0];
                            draw_y      <= fy1[CW-1:0];
                            draw_colour <= col;
                        end
                    end
                end
                S_FLIP: begin
                    // The next cell is written and presented on the same edge the current one is taken.
                    if (xfer) begin
                        if (rem == (CW+1)'(1)) begin
                            draw_req <= 1'b0;
                        end else begin
                            board_out[2*nidx +: 2] <= col;
                            draw_x <= nx;
                            draw_y <= ny;
                        end
                    end
                end
                S_PLACE: begin
                    valid <= (flip_count != '0);
                    if (flip_count != '0 && !chk) begin
                        board_out[2*oidx +: 2] <= col;
                        draw_req    <= 1'b1;
                        draw_x      <= tx;
                        draw_y      <= ty;
                        draw_colour <= col;
                    end
                end
                S_PLACE_DRAW: if (xfer) draw_req <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_reversi_flip_engine.sv
// Directed bench for reversi_flip_engine: N=8 main instance, N=4 edge/reset instance,
// N=6 instance for out-of-range coordinates.
module tb_reversi_flip_engine;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_run = 0;
    int n_fail = 0;

    // N = 8
    logic         start8, chk8, busy8, done8, valid8, dreq8, drdy8;
    logic [2:0]   px8, py8, dx8, dy8;
    logic [1:0]   col8, dcol8;
    logic [127:0] bin8, bout8;
    logic [5:0]   fc8;
    // N = 4
    logic         start4, chk4, busy4, done4, valid4, dreq4, drdy4;
    logic [1:0]   px4, py4, dx4, dy4, col4, dcol4;
    logic [31:0]  bin4, bout4;
    logic [4:0]   fc4;
    // N = 6
    logic         start6, chk6, busy6, done6, valid6, dreq6, drdy6;
    logic [2:0]   px6, py6, dx6, dy6;
    logic [1:0]   col6, dcol6;
    logic [71:0]  bin6, bout6;
    logic [5:0]   fc6;

    reversi_flip_engine #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .px(px8), .py(py8), .colour(col8),
        .check_only(chk8), .board_in(bin8), .busy(busy8), .done(done8), .valid(valid8),
        .flip_count(fc8), .board_out(bout8), .draw_req(dreq8), .draw_ready(drdy8),
        .draw_x(dx8), .draw_y(dy8), .draw_colour(dcol8));

    reversi_flip_engine #(.N(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .px(px4), .py(py4), .colour(col4),
        .check_only(chk4), .board_in(bin4), .busy(busy4), .done(done4), .valid(valid4),
        .flip_count(fc4), .board_out(bout4), .draw_req(dreq4), .draw_ready(drdy4),
        .draw_x(dx4), .draw_y(dy4), .draw_colour(dcol4));

    reversi_flip_engine #(.N(6)) dut6 (
        .clk(clk), .reset(reset), .start(start6), .px(px6), .py(py6), .colour(col6),
        .check_only(chk6), .board_in(bin6), .busy(busy6), .done(done6), .valid(valid6),
        .flip_count(fc6), .board_out(bout6), .draw_req(dreq6), .draw_ready(drdy6),
        .draw_x(dx6), .draw_y(dy6), .draw_colour(dcol6));

    // Log of completed draw transfers on the N=8 instance: {x, y, colour}.
    logic [7:0] log8 [0:63];
    int log_n = 0;
    always @(posedge clk) begin
        if (dreq8 && drdy8 && log_n < 64) begin
            log8[log_n] <= {dx8, dy8, dcol8};
            log_n <= log_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] setc(input logic [127:0] b, input int n, input int x,
                                          input int y, input logic [1:0] c);
        b[2*(y*n+x) +: 2] = c;
        return b;
    endfunction

    task automatic go8(input logic [2:0] x, input logic [2:0] y, input logic [1:0] c,
                       input logic co, input logic [127:0] b);
        @(negedge clk);
        px8 = x; py8 = y; col8 = c; chk8 = co; bin8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk("busy8_after_start", {busy8, done8}, 2'b10);
    endtask

    task automatic wait8(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (done8) break;
            @(negedge clk);
        end
        chk(tag, done8, 1'b1);
    endtask

    task automatic go4(input logic [1:0] x, input logic [1:0] y, input logic [31:0] b);
        @(negedge clk);
        px4 = x; py4 = y; col4 = 2'b10; chk4 = 1'b0; bin4 = b; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic wait4(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (done4) break;
            @(negedge clk);
        end
        chk(tag, done4, 1'b1);
    endtask

    logic [127:0] ob, exp_b, mb;
    logic [31:0]  b4a, b4b, e4a;
    logic [7:0]   mexp [0:4];
    int base;

    initial begin
        reset = 1'b1;
        start8 = 0; chk8 = 0; px8 = 0; py8 = 0; col8 = 0; bin8 = '0; drdy8 = 1'b1;
        start4 = 0; chk4 = 0; px4 = 0; py4 = 0; col4 = 0; bin4 = '0; drdy4 = 1'b1;
        start6 = 0; chk6 = 0; px6 = 0; py6 = 0; col6 = 0; bin6 = '0; drdy6 = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset8", {busy8, done8, valid8, fc8, dreq8, dx8, dy8, dcol8}, '0);
        chk("reset8_board", bout8, '0);
        reset = 1'b0;

        ob = '0;
        ob = setc(ob, 8, 3, 3, 2'b01);
        ob = setc(ob, 8, 4, 4, 2'b01);
        ob = setc(ob, 8, 3, 4, 2'b10);
        ob = setc(ob, 8, 4, 3, 2'b10);

        // Opening move: black to (2,3) flips (3,3).
        base = log_n;
        go8(3'd2, 3'd3, 2'b10, 1'b0, ob);
        wait8("open_done");
        exp_b = setc(setc(ob, 8, 3, 3, 2'b10), 8, 2, 3, 2'b10);
        chk("open_valid", valid8, 1'b1);
        chk("open_count", fc8, 6'd1);
        chk("open_board", bout8, exp_b);
        chk("open_ndraw", log_n - base, 2);
        chk("open_draw0", log8[base], {3'd3, 3'd3, 2'b10});
        chk("open_draw1", log8[base+1], {3'd2, 3'd3, 2'b10});
        @(negedge clk);
        chk("open_done_pulse", {busy8, done8}, 2'b00);
        chk("open_hold", {valid8, fc8}, {1'b1, 6'd1});

        // Occupied origin: rejected, done two cycles after acceptance.
        base = log_n;
        go8(3'd3, 3'd3, 2'b10, 1'b0, ob);
        @(negedge clk);
        chk("occ_done_t2", done8, 1'b1);
        chk("occ_result", {valid8, fc8}, '0);
        chk("occ_board", bout8, ob);
        chk("occ_ndraw", log_n - base, 0);

        // Corner (0,0): all directions scanned, nothing bracketed.
        base = log_n;
        go8(3'd0, 3'd0, 2'b10, 1'b0, ob);
        wait8("corner_done");
        chk("corner_result", {valid8, fc8}, '0);
        chk("corner_board", bout8, ob);
        chk("corner_ndraw", log_n - base, 0);

        // Reserved colour 11 is rejected at the origin.
        go8(3'd2, 3'd3, 2'b11, 1'b0, ob);
        @(negedge clk);
        chk("badcol_done_t2", done8, 1'b1);
        chk("badcol_valid", valid8, 1'b0);

        // Check-only on the opening move.
        base = log_n;
        go8(3'd2, 3'd3, 2'b10, 1'b1, ob);
        wait8("chk_done");
        chk("chk_result", {valid8, fc8}, {1'b1, 6'd1});
        chk("chk_board", bout8, ob);
        chk("chk_ndraw", log_n - base, 0);

        // Multi-direction move from (3,3) with a stalled drawer mid-flip.
        mb = '0;
        mb = setc(mb, 8, 4, 3, 2'b01);
        mb = setc(mb, 8, 5, 3, 2'b01);
        mb = setc(mb, 8, 6, 3, 2'b10);
        mb = setc(mb, 8, 3, 4, 2'b01);
        mb = setc(mb, 8, 3, 5, 2'b10);
        mb = setc(mb, 8, 4, 4, 2'b01);
        mb = setc(mb, 8, 5, 5, 2'b10);
        mexp[0] = {3'd4, 3'd3, 2'b10};
        mexp[1] = {3'd5, 3'd3, 2'b10};
        mexp[2] = {3'd3, 3'd4, 2'b10};
        mexp[3] = {3'd4, 3'd4, 2'b10};
        mexp[4] = {3'd3, 3'd3, 2'b10};
        exp_b = mb;
        for (int i = 0; i < 5; i++)
            exp_b = setc(exp_b, 8, int'(mexp[i][7:5]), int'(mexp[i][4:2]), 2'b10);
        base = log_n;
        drdy8 = 1'b0;
        go8(3'd3, 3'd3, 2'b10, 1'b0, mb);
        for (int i = 0; i < 100; i++) begin
            if (dreq8) break;
            @(negedge clk);
        end
        chk("multi_first_req", {dreq8, dx8, dy8, dcol8}, {1'b1, mexp[0]});
        drdy8 = 1'b1;
        @(negedge clk);
        drdy8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("multi_stall_hold", {dreq8, dx8, dy8, dcol8}, {1'b1, mexp[1]});
        end
        drdy8 = 1'b1;
        wait8("multi_done");
        chk("multi_result", {valid8, fc8}, {1'b1, 6'd4});
        chk("multi_board", bout8, exp_b);
        chk("multi_ndraw", log_n - base, 5);
        for (int i = 0; i < 5; i++)
            chk("multi_draw_order", log8[base+i], mexp[i]);

        // N=6: column 6 is off the board.
        @(negedge clk);
        px6 = 3'd6; py6 = 3'd0; col6 = 2'b10; chk6 = 1'b0; bin6 = '0; start6 = 1'b1;
        @(negedge clk);
        start6 = 1'b0;
        chk("n6_busy", busy6, 1'b1);
        @(negedge clk);
        chk("n6_done_t2", done6, 1'b1);
        chk("n6_result", {valid6, fc6, dreq6}, '0);

        // N=4: bracket ending on the edge column.
        b4a = '0;
        b4a = 32'(setc(128'(b4a), 4, 1, 1, 2'b01));
        b4a = 32'(setc(128'(b4a), 4, 2, 1, 2'b01));
        b4a = 32'(setc(128'(b4a), 4, 3, 1, 2'b10));
        e4a = 32'(setc(setc(setc(128'(b4a), 4, 0, 1, 2'b10), 4, 1, 1, 2'b10), 4, 2, 1, 2'b10));
        go4(2'd0, 2'd1, b4a);
        wait4("n4_edge_done");
        chk("n4_edge_result", {valid4, fc4}, {1'b1, 5'd2});
        chk("n4_edge_board", bout4, e4a);

        // N=4: run of opponents off the east edge; (0,3) would be reached by a wrap.
        b4b = '0;
        b4b = 32'(setc(128'(b4b), 4, 1, 2, 2'b01));
        b4b = 32'(setc(128'(b4b), 4, 2, 2, 2'b01));
        b4b = 32'(setc(128'(b4b), 4, 3, 2, 2'b01));
        b4b = 32'(setc(128'(b4b), 4, 0, 3, 2'b10));
        go4(2'd0, 2'd2, b4b);
        wait4("n4_nowrap_done");
        chk("n4_nowrap_result", {valid4, fc4}, '0);
        chk("n4_nowrap_board", bout4, b4b);

        // Reset while a flip draw is waiting on the drawer.
        drdy4 = 1'b0;
        go4(2'd0, 2'd1, b4a);
        for (int i = 0; i < 100; i++) begin
            if (dreq4) break;
            @(negedge clk);
        end
        chk("n4_flip_req", {dreq4, busy4}, 2'b11);
        reset = 1'b1;
        @(negedge clk);
        chk("n4_reset_mid", {busy4, done4, valid4, fc4, bout4, dreq4, dx4, dy4, dcol4}, '0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
